// File: rtl/chess_lmg_pkg.sv
// Shared constants, types and helpers for the LMG move FIFO.
// The packer builds words with these definitions and the control block unpacks them with the same ones.
package chess_lmg_pkg;

    localparam int MOVE_W     = 18;
    localparam int SLOTS      = 8;
    localparam int SLOT_W     = MOVE_W + 1;
    localparam int WORD_W     = SLOT_W * SLOTS;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int SLOT_IDX_W = $clog2(SLOTS);
    localparam int COUNT_W    = 8;

    typedef logic [MOVE_W-1:0] move_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FLUSH,
        ST_TERM,
        ST_DONE
    } packState_t;

    // Bit offset of slot k; the slot's invalid flag sits at slotOffset(k) + MOVE_W.
    function automatic int slotOffset(input int k);
        return k * SLOT_W;
    endfunction

    // Word with every slot flagged invalid and every move field zero.
    function automatic word_t makeInvalidWord();
        word_t w;
        w = '0;
        for (int k = 0; k < SLOTS; k++) begin
            w[slotOffset(k) + MOVE_W] = 1'b1;
        end
        return w;
    endfunction

    localparam word_t INVALID_WORD = makeInvalidWord();

endpackage

// File: rtl/lmg_move_packer_if.sv
// Move-generator / control-block handshake bundle for the LMG move packer.
// master = the side driving moves and pops, slave = the packer.
interface lmg_move_packer_if;
    import chess_lmg_pkg::*;

    logic               start;
    logic               mv_valid;
    move_t              mv_data;
    logic               mv_ready;
    logic               gen_last;
    logic               rden;
    word_t              fifo_out;
    logic               fifo_empty;
    logic               done;
    logic [COUNT_W-1:0] move_count;

    modport master (
        output start, mv_valid, mv_data, gen_last, rden,
        input  mv_ready, fifo_out, fifo_empty, done, move_count
    );

    modport slave (
        input  start, mv_valid, mv_data, gen_last, rden,
        output mv_ready, fifo_out, fifo_empty, done, move_count
    );

endinterface

// File: rtl/lmg_word_fifo.sv
// Synchronous word FIFO with a registered read port and a synchronous clear.
// Full/empty are decoded from an occupancy counter one bit wider than the pointers.
module lmg_word_fifo
    import chess_lmg_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  word_t       pushData,
    input  logic        pop,
    output word_t       popData,
    output logic        full,
    output logic        empty,
    output logic [AW:0] occupancy
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    word_t         mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign full   = (occupancy == FULL_COUNT);
    assign empty  = (occupancy == '0);
    // A clear cycle discards the buffer, so nothing else happens to it that cycle.
    assign doPush = push && !full && !clear;
    assign doPop  = pop && !empty && !clear;

    // Storage write port.
    // NOTE: the array is deliberately left out of reset; occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
            popData   <= INVALID_WORD;
        end else if (clear) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr   <= rdPtr + 1'b1;
                popData <= mem[rdPtr];
            end
            case ({doPush, doPop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lmg_move_packer.sv
// Producer end of the LMG move FIFO: packs single moves eight to a word with per-slot
// invalid flags, flushes a partial word and an all-invalid terminator at generation end,
// and buffers words for the control block.
module lmg_move_packer
    import chess_lmg_pkg::*;
(
    input logic              clk,
    input logic              reset_n,
    lmg_move_packer_if.slave bus
);

    localparam logic [SLOT_IDX_W-1:0] LAST_SLOT  = SLOT_IDX_W'(SLOTS - 1);
    localparam logic [ADDR_W:0]       FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [COUNT_W-1:0]    COUNT_MAX  = '1;

    packState_t              state;
    packState_t              nextState;
    word_t                   packReg;
    word_t                   packNext;
    logic [SLOT_IDX_W-1:0]   slotIdx;
    logic [SLOT_IDX_W-1:0]   slotNext;
    logic [COUNT_W-1:0]      moveCount;
    logic                    accept;
    logic                    mvReady;
    logic                    pushReq;
    word_t                   pushWord;
    logic                    fifoFull;
    logic                    fifoEmpty;
    logic [ADDR_W:0]         fifoCount;

    lmg_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (bus.start),
        .push      (pushReq),
        .pushData  (pushWord),
        .pop       (bus.rden),
        .popData   (bus.fifo_out),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .occupancy (fifoCount)
    );

    assign bus.mv_ready   = mvReady;
    assign bus.fifo_empty = fifoEmpty;
    assign bus.done       = (state == ST_DONE);
    assign bus.move_count = moveCount;

    // Next state, move acceptance, slot insertion and word push selection.
    always_comb begin
        // NOTE: every signal gets its default first so no path through the case can infer a latch.
        nextState = state;
        packNext  = packReg;
        slotNext  = slotIdx;
        accept    = 1'b0;
        mvReady   = 1'b0;
        pushReq   = 1'b0;
        pushWord  = packReg;

        if (bus.start) begin
            // Restart wins over everything; a move offered this cycle is refused.
            nextState = ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: begin
                    mvReady = !fifoFull;
                    if (bus.mv_valid && !fifoFull) begin
                        accept = 1'b1;
                        packNext[slotOffset(int'(slotIdx)) +: SLOT_W] = {1'b0, bus.mv_data};
                        if (slotIdx == LAST_SLOT) begin
                            // Eighth move completes the word: push it and start a fresh one.
                            pushReq  = 1'b1;
                            pushWord = packNext;
                            packNext = INVALID_WORD;
                            slotNext = '0;
                        end else begin
                            slotNext = slotIdx + 1'b1;
                        end
                    end
                    // A blocked move must land before the generation may end.
                    if (bus.gen_last && (!bus.mv_valid || accept)) begin
                        nextState = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (slotIdx == '0) begin
                        nextState = ST_TERM;
                    end else if (!fifoFull) begin
                        pushReq   = 1'b1;
                        pushWord  = packReg;
                        packNext  = INVALID_WORD;
                        slotNext  = '0;
                        nextState = ST_TERM;
                    end
                end
                ST_TERM: begin
                    if (!fifoFull) begin
                        pushReq   = 1'b1;
                        pushWord  = INVALID_WORD;
                        nextState = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Pack register and slot index; start discards any partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            packReg <= INVALID_WORD;
            slotIdx <= '0;
        end else if (bus.start) begin
            packReg <= INVALID_WORD;
            slotIdx <= '0;
        end else begin
            packReg <= packNext;
            slotIdx <= slotNext;
        end
    end

    // Saturating count of moves accepted since start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            moveCount <= '0;
        end else if (bus.start) begin
            moveCount <= '0;
        end else if (accept && (moveCount != COUNT_MAX)) begin
            moveCount <= moveCount + 1'b1;
        end
    end

    // The buffer must never report more words than it can hold.
    occupancyBound: assert property (@(posedge clk) disable iff (!reset_n) fifoCount <= FULL_COUNT);

endmodule

// File: tb/tb_lmg_move_packer.sv
// Self-checking bench for lmg_move_packer: a bench-side packing model pushes expected
// words into a scoreboard queue as moves are sent; words are popped and compared on drain.
module tb_lmg_move_packer;

    logic clk = 1'b0;
    logic reset_n;

    lmg_move_packer_if bus ();

    lmg_move_packer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int           testsRun    = 0;
    int           testsFailed = 0;
    logic [151:0] expQ[$];
    logic [17:0]  pending[8];
    int           pendCnt     = 0;
    logic [151:0] invalidWord;

    // Word built from the first n pending moves; remaining slots flagged invalid.
    function automatic logic [151:0] build_word(input int n);
        logic [151:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) w[19*k +: 19] = {1'b0, pending[k]};
            else       w[19*k + 18]  = 1'b1;
        end
        return w;
    endfunction

    task automatic model_clear();
        expQ.delete();
        pendCnt = 0;
    endtask

    task automatic model_add(input logic [17:0] m);
        pending[pendCnt] = m;
        pendCnt++;
        if (pendCnt == 8) begin
            expQ.push_back(build_word(8));
            pendCnt = 0;
        end
    endtask

    task automatic model_end();
        if (pendCnt != 0) expQ.push_back(build_word(pendCnt));
        expQ.push_back(invalidWord);
        pendCnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        model_clear();
    endtask

    // Offer one move until accepted or the cycle budget runs out.
    task automatic send_move(input logic [17:0] m, input int budget, output bit ok);
        ok = 1'b0;
        bus.mv_valid = 1'b1;
        bus.mv_data  = m;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.mv_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.mv_valid = 1'b0;
        if (ok) begin
            model_add(m);
        end else begin
            testsRun++;
            testsFailed++;
            $display("FAIL send_move: move %h mv_ready got 0 required 1 within %0d cycles", m, budget);
        end
    endtask

    // Signal generation end and wait (bounded) for done.
    task automatic finish_gen(input string name);
        bus.mv_valid = 1'b0;
        bus.gen_last = 1'b1;
        tick();
        bus.gen_last = 1'b0;
        model_end();
        for (int i = 0; i < 50 && bus.done !== 1'b1; i++) tick();
        testsRun++;
        if (bus.done !== 1'b1) begin
            testsFailed++;
            $display("FAIL %s_done: got %b required 1", name, bus.done);
        end
        testsRun++;
        if (bus.fifo_empty !== 1'b0) begin
            testsFailed++;
            $display("FAIL %s_empty_at_done: got %b required 0", name, bus.fifo_empty);
        end
    endtask

    // Pop until empty, comparing each word against the scoreboard.
    task automatic drain(input string name, output int popped);
        logic [151:0] exp;
        popped = 0;
        while (bus.fifo_empty === 1'b0 && popped < 64) begin
            bus.rden = 1'b1;
            tick();
            bus.rden = 1'b0;
            popped++;
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("FAIL %s_extra: got word %h required none", name, bus.fifo_out);
            end else begin
                exp = expQ.pop_front();
                if (bus.fifo_out !== exp) begin
                    testsFailed++;
                    $display("FAIL %s_word%0d: got %h required %h", name, popped - 1, bus.fifo_out, exp);
                end
            end
        end
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL %s_missing: got %0d words left unpopped required 0", name, expQ.size());
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.mv_valid = 1'b0; bus.mv_data = '0;
        bus.gen_last = 1'b0; bus.rden = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        testsRun++;
        if (bus.fifo_empty !== 1'b1) begin testsFailed++; $display("FAIL reset_empty: got %b required 1", bus.fifo_empty); end
        testsRun++;
        if (bus.done !== 1'b0) begin testsFailed++; $display("FAIL reset_done: got %b required 0", bus.done); end
        testsRun++;
        if (bus.mv_ready !== 1'b0) begin testsFailed++; $display("FAIL reset_ready: got %b required 0", bus.mv_ready); end
        testsRun++;
        if (bus.move_count !== 8'd0) begin testsFailed++; $display("FAIL reset_count: got %0d required 0", bus.move_count); end
        testsRun++;
        if (bus.fifo_out !== invalidWord) begin testsFailed++; $display("FAIL reset_out: got %h required %h", bus.fifo_out, invalidWord); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_three_moves();
        bit ok;
        int n;
        pulse_start();
        send_move(18'h00001, 10, ok);
        send_move(18'h00002, 10, ok);
        send_move(18'h00003, 10, ok);
        finish_gen("three");
        testsRun++;
        if (bus.move_count !== 8'd3) begin testsFailed++; $display("FAIL three_count: got %0d required 3", bus.move_count); end
        drain("three", n);
        testsRun++;
        if (n != 2) begin testsFailed++; $display("FAIL three_words: got %0d required 2", n); end
    endtask

    task automatic test_full_word();
        bit ok;
        int n;
        pulse_start();
        for (int i = 0; i < 8; i++) send_move(18'(18'h00010 + i), 10, ok);
        finish_gen("full");
        drain("full", n);
        testsRun++;
        if (n != 2) begin testsFailed++; $display("FAIL full_words: got %0d required 2", n); end
    endtask

    task automatic test_empty_gen();
        int n;
        pulse_start();
        finish_gen("empty_gen");
        testsRun++;
        if (bus.move_count !== 8'd0) begin testsFailed++; $display("FAIL empty_gen_count: got %0d required 0", bus.move_count); end
        drain("empty_gen", n);
        testsRun++;
        if (n != 1) begin testsFailed++; $display("FAIL empty_gen_words: got %0d required 1", n); end
        // Pop attempt on an empty FIFO must leave the output word alone.
        bus.rden = 1'b1;
        tick();
        bus.rden = 1'b0;
        testsRun++;
        if (bus.fifo_out !== invalidWord) begin testsFailed++; $display("FAIL underflow_out: got %h required %h", bus.fifo_out, invalidWord); end
        testsRun++;
        if (bus.fifo_empty !== 1'b1) begin testsFailed++; $display("FAIL underflow_empty: got %b required 1", bus.fifo_empty); end
    endtask

    task automatic test_backpressure();
        bit           ok;
        int           n;
        logic [151:0] exp;
        pulse_start();
        for (int i = 0; i < 128; i++) begin
            send_move(18'(18'h00100 + i), 4, ok);
            if (!ok) break;
        end
        bus.mv_valid = 1'b1;
        bus.mv_data  = 18'h00180;
        @(negedge clk);
        testsRun++;
        if (bus.mv_ready !== 1'b0) begin testsFailed++; $display("FAIL bp_ready_full: got %b required 0", bus.mv_ready); end
        tick();
        bus.rden = 1'b1;
        tick();
        bus.rden = 1'b0;
        exp = expQ.pop_front();
        testsRun++;
        if (bus.fifo_out !== exp) begin testsFailed++; $display("FAIL bp_first_pop: got %h required %h", bus.fifo_out, exp); end
        @(negedge clk);
        testsRun++;
        if (bus.mv_ready !== 1'b1) begin testsFailed++; $display("FAIL bp_ready_after_pop: got %b required 1", bus.mv_ready); end
        tick();
        bus.mv_valid = 1'b0;
        model_add(18'h00180);
        send_move(18'h00181, 10, ok);
        drain("bp_body", n);
        finish_gen("bp");
        drain("bp_tail", n);
        testsRun++;
        if (n != 2) begin testsFailed++; $display("FAIL bp_tail_words: got %0d required 2", n); end
        testsRun++;
        if (bus.move_count !== 8'd130) begin testsFailed++; $display("FAIL bp_count: got %0d required 130", bus.move_count); end
    endtask

    task automatic test_restart();
        bit ok;
        int n;
        pulse_start();
        for (int i = 0; i < 5; i++) send_move(18'(18'h00200 + i), 10, ok);
        // Restart with a move offered in the same cycle: the move must be refused.
        bus.mv_valid = 1'b1;
        bus.mv_data  = 18'h3FFFF;
        bus.start    = 1'b1;
        @(negedge clk);
        testsRun++;
        if (bus.mv_ready !== 1'b0) begin testsFailed++; $display("FAIL restart_ready: got %b required 0", bus.mv_ready); end
        tick();
        bus.start    = 1'b0;
        bus.mv_valid = 1'b0;
        model_clear();
        testsRun++;
        if (bus.fifo_empty !== 1'b1) begin testsFailed++; $display("FAIL restart_empty: got %b required 1", bus.fifo_empty); end
        testsRun++;
        if (bus.done !== 1'b0) begin testsFailed++; $display("FAIL restart_done: got %b required 0", bus.done); end
        testsRun++;
        if (bus.move_count !== 8'd0) begin testsFailed++; $display("FAIL restart_count: got %0d required 0", bus.move_count); end
        send_move(18'h2ABCD, 10, ok);
        finish_gen("restart");
        testsRun++;
        if (bus.move_count !== 8'd1) begin testsFailed++; $display("FAIL restart_final_count: got %0d required 1", bus.move_count); end
        drain("restart", n);
    endtask

    initial begin
        invalidWord = '0;
        for (int k = 0; k < 8; k++) invalidWord[19*k + 18] = 1'b1;
        test_reset();
        test_three_moves();
        test_full_word();
        test_empty_gen();
        test_backpressure();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Last-resort bound on total run time.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
